lifo_ctrl_5bit: RTL

Controller that turns push/pop/clear requests into the cntU/cntD/rst5 controls consumed by the 5-bit up/down counter and drives a 32-word synchronous-read RAM. It uses the counter's result and down_done as its stack pointer and empty flag. Together with the counter and RAM, it forms a LIFO of up to 31 entries.

---
 rtl/lifo_ctrl_5bit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lifo_ctrl_5bit.sv
// LIFO controller: drives a 5-bit up/down counter and a 32x DATA_W sync RAM.
// Ports: push/pop/clr requests in, cntU/cntD/rst5 + RAM controls out, status out.
module lifo_ctrl_5bit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  input  logic              clr,
  input  logic [4:0]        cnt_result,
  input  logic              down_done,
  output logic              cntU,
  output logic              cntD,
  output logic              rst5,
  output logic              mem_we,
  output logic              mem_re,
  output logic [4:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              push_ack,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_DEC,
    S_POP_RD,
    S_POP_CAP,
    S_CLEAR
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pop_data_q;
  logic              err_q;
  logic              pop_valid_q;

  logic take_clr;
  logic take_pop;
  logic take_push;
  logic pop_ok;
  logic pop_bad;
  logic push_ok;
  logic push_bad;
  logic idle;

  assign full  = (cnt_result == 5'd31);
  assign empty = down_done;
  assign idle  = (state_q == S_IDLE);

  // clr beats pop, pop beats push
  assign take_clr  = clr;
  assign take_pop  = !clr && pop_req;
  assign take_push = !clr && !pop_req && push_req;

  assign pop_ok   = take_pop && !empty;
  assign pop_bad  = take_pop && empty;
  assign push_ok  = take_push && !full;
  assign push_bad = take_push && full;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          take_clr: state_d = S_CLEAR;
          pop_ok:   state_d = S_POP_DEC;
          push_ok:  state_d = S_PUSH;
          default:  state_d = S_IDLE;
        endcase
      end
      S_PUSH:    state_d = S_IDLE;
      S_POP_DEC: state_d = S_POP_RD;
      S_POP_RD:  state_d = S_POP_CAP;
      S_POP_CAP: state_d = S_IDLE;
      S_CLEAR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (idle && push_ok) begin
      data_q <= push_data;
    end
  end

  // Rejections only happen from IDLE, so a one-cycle flag is enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= idle && (pop_bad || push_bad);
    end
  end

  // RAM read data lands during POP_CAP; latch it on the way out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= (state_q == S_POP_CAP);
      if (state_q == S_POP_CAP) begin
        pop_data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    cntU      = 1'b0;
    cntD      = 1'b0;
    rst5      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 5'd0;
    mem_wdata = '0;
    push_ack  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_result;
        mem_wdata = data_q;
        cntU      = 1'b1;
        push_ack  = 1'b1;
      end
      S_POP_DEC: begin
        cntD = 1'b1;
      end
      S_POP_RD: begin
        // counter already decremented: points at top entry
        mem_re   = 1'b1;
        mem_addr = cnt_result;
      end
      S_POP_CAP: begin
        busy = 1'b1;
      end
      S_CLEAR: begin
        rst5 = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign err       = err_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;

endmodule
